// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared constants for the 8-bit bus CPU control sequencer
// Rev 1.0
// ============================================================================
package cpu_pkg;

  localparam int CTRL_W = 16;
  localparam int STEP_W = 3;

  // Control word bit positions
  localparam int CB_AI  = 0;
  localparam int CB_AO  = 1;
  localparam int CB_BI  = 2;
  localparam int CB_BO  = 3;
  localparam int CB_II  = 4;
  localparam int CB_IO  = 5;
  localparam int CB_IIO = 6;
  localparam int CB_OI  = 7;
  localparam int CB_OO  = 8;
  localparam int CB_MI  = 9;
  localparam int CB_MO  = 10;
  localparam int CB_CE  = 11;
  localparam int CB_CO  = 12;
  localparam int CB_J   = 13;
  localparam int CB_EO  = 14;
  localparam int CB_SU  = 15;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_ucode.sv
`default_nettype none
// ============================================================================
// cpu_ucode : combinational microcode ROM, (stage, opcode, flags) -> control
// Rev 1.0
// ============================================================================
module cpu_ucode
  import cpu_pkg::*;
(
  input  logic [STEP_W-1:0] i_stage,
  input  logic [3:0]        i_opcode,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_last,
  output logic              o_illegal,
  output logic              o_is_hlt
);

  always_comb begin
    o_ctrl    = '0;
    o_last    = 1'b0;
    o_illegal = 1'b0;
    o_is_hlt  = 1'b0;
    case (i_stage)
      T0: begin
        o_ctrl[CB_CO] = 1'b1;
        o_ctrl[CB_MI] = 1'b1;
      end
      T1: begin
        o_ctrl[CB_MO] = 1'b1;
        o_ctrl[CB_II] = 1'b1;
        o_ctrl[CB_CE] = 1'b1;
      end
      T2: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_NOP: ;
          OP_LDA, OP_ADD, OP_SUB: begin
            o_last         = 1'b0;
            o_ctrl[CB_IO]  = 1'b1;
            o_ctrl[CB_IIO] = 1'b1;
            o_ctrl[CB_MI]  = 1'b1;
          end
          OP_LDI: begin
            o_ctrl[CB_IO]  = 1'b1;
            o_ctrl[CB_IIO] = 1'b1;
            o_ctrl[CB_AI]  = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            // Conditional jumps still retire in T2 when not taken
            if (i_opcode == OP_JMP ||
                (i_opcode == OP_JC && i_flag_c) ||
                (i_opcode == OP_JZ && i_flag_z)) begin
              o_ctrl[CB_IO]  = 1'b1;
              o_ctrl[CB_IIO] = 1'b1;
              o_ctrl[CB_J]   = 1'b1;
            end
          end
          OP_OUT: begin
            o_ctrl[CB_AO] = 1'b1;
            o_ctrl[CB_OI] = 1'b1;
          end
          OP_HLT:  o_is_hlt  = 1'b1;
          default: o_illegal = 1'b1;
        endcase
      end
      T3: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA: begin
            o_ctrl[CB_MO] = 1'b1;
            o_ctrl[CB_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_last        = 1'b0;
            o_ctrl[CB_MO] = 1'b1;
            o_ctrl[CB_BI] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        o_last = 1'b1;
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_ctrl[CB_EO] = 1'b1;
          o_ctrl[CB_AI] = 1'b1;
          o_ctrl[CB_SU] = (i_opcode == OP_SUB);
        end
      end
      // Unreachable stages retire immediately so the sequencer recovers to T0
      default: o_last = 1'b1;
    endcase
  end

endmodule : cpu_ucode
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_seq : stage counter, halt/run gating and retired-instruction count
// Rev 1.0
// ============================================================================
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int STEP_W = cpu_pkg::STEP_W,
  parameter int ICNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_opcode,
  input  logic              i_flag_c,
  input  logic              i_flag_z,
  input  logic              i_run,
  input  logic              i_step,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [STEP_W-1:0] o_stage,
  output logic              o_last,
  output logic              o_illegal,
  output logic              o_halted,
  output logic [ICNT_W-1:0] o_icount
);

  logic [STEP_W-1:0] stage_q, stage_d;
  logic              halted_q, halted_d;
  logic [ICNT_W-1:0] icount_q, icount_d;

  logic [CTRL_W-1:0] uc_ctrl;
  logic              uc_last, uc_illegal, uc_is_hlt;
  logic              advance;

  cpu_ucode u_ucode (
    .i_stage   (stage_q),
    .i_opcode  (i_opcode),
    .i_flag_c  (i_flag_c),
    .i_flag_z  (i_flag_z),
    .o_ctrl    (uc_ctrl),
    .o_last    (uc_last),
    .o_illegal (uc_illegal),
    .o_is_hlt  (uc_is_hlt)
  );

  assign advance = ~halted_q & (i_run | i_step);

  always_comb begin
    stage_d  = stage_q;
    halted_d = halted_q;
    icount_d = icount_q;
    if (advance) begin
      stage_d = uc_last ? '0 : stage_q + 1'b1;
      if (uc_last) begin
        icount_d = icount_q + 1'b1;
        halted_d = uc_is_hlt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_q  <= '0;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      stage_q  <= stage_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  assign o_ctrl    = advance ? uc_ctrl : '0;
  assign o_last    = advance & uc_last;
  assign o_illegal = advance & uc_illegal;
  assign o_stage   = stage_q;
  assign o_halted  = halted_q;
  assign o_icount  = icount_q;

endmodule : cpu_ctrl_seq
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_cpu_ctrl_seq : directed self-checking bench for cpu_ctrl_seq
// Rev 1.0
// ============================================================================
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [15:0] ctrl;
  logic [2:0]  stage;
  logic        last, illegal, halted;
  logic [7:0]  icount;

  int errors = 0;
  int checks = 0;

  cpu_ctrl_seq dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_opcode  (opcode),
    .i_flag_c  (flag_c),
    .i_flag_z  (flag_z),
    .i_run     (run),
    .i_step    (step),
    .o_ctrl    (ctrl),
    .o_stage   (stage),
    .o_last    (last),
    .o_illegal (illegal),
    .o_halted  (halted),
    .o_icount  (icount)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, then settle mid-cycle
  task automatic cyc(input logic r, input logic s, input logic [3:0] op,
                     input logic c, input logic z);
    @(negedge clk);
    run = r; step = s; opcode = op; flag_c = c; flag_z = z;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 4'h5, 0, 0);
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (icount !== 8'd0) begin errors++; $display("FAIL reset_icount got %0d want 0", icount); end
    checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl_idle got %h want 0000", ctrl); end
  endtask

  task automatic test_ldi();
    logic [15:0] ec [3] = '{16'h1200, 16'h0C10, 16'h0061};
    logic        el [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'h5, 0, 0);
      checks++; if (stage !== 3'(i)) begin errors++; $display("FAIL ldi_stage cyc%0d got %0d want %0d", i, stage, i); end
      checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL ldi_ctrl cyc%0d got %h want %h", i, ctrl, ec[i]); end
      checks++; if (last !== el[i]) begin errors++; $display("FAIL ldi_last cyc%0d got %b want %b", i, last, el[i]); end
    end
    cyc(0, 0, 4'h5, 0, 0);
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL ldi_wrap_stage got %0d want 0", stage); end
    checks++; if (icount !== 8'd1) begin errors++; $display("FAIL ldi_icount got %0d want 1", icount); end
  endtask

  task automatic test_add_sub();
    logic [15:0] ea [5] = '{16'h1200, 16'h0C10, 16'h0260, 16'h0404, 16'h4001};
    logic [15:0] es [5] = '{16'h1200, 16'h0C10, 16'h0260, 16'h0404, 16'hC001};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(1, 0, (k == 0) ? 4'h2 : 4'h3, 0, 0);
        checks++;
        if (ctrl !== ((k == 0) ? ea[i] : es[i])) begin
          errors++;
          $display("FAIL addsub_ctrl op%0d T%0d got %h want %h", k + 2, i, ctrl, (k == 0) ? ea[i] : es[i]);
        end
        checks++; if (last !== (i == 4)) begin errors++; $display("FAIL addsub_last op%0d T%0d got %b want %b", k + 2, i, last, i == 4); end
      end
    end
    cyc(0, 0, 4'h0, 0, 0);
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL addsub_stage got %0d want 0", stage); end
    checks++; if (icount !== 8'd3) begin errors++; $display("FAIL addsub_icount got %0d want 3", icount); end
  endtask

  task automatic test_jumps_t2();
    logic [3:0]  op [6] = '{4'h7, 4'h7, 4'h8, 4'h8, 4'hE, 4'h6};
    logic        fc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        fz [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] e2 [6] = '{16'h0000, 16'h2060, 16'h2060, 16'h0000, 16'h0082, 16'h2060};
    for (int n = 0; n < 6; n++) begin
      cyc(1, 0, op[n], fc[n], fz[n]);
      cyc(1, 0, op[n], fc[n], fz[n]);
      cyc(1, 0, op[n], fc[n], fz[n]);
      checks++; if (ctrl !== e2[n]) begin errors++; $display("FAIL jump_t2_ctrl case%0d got %h want %h", n, ctrl, e2[n]); end
      checks++; if (last !== 1'b1) begin errors++; $display("FAIL jump_t2_last case%0d got %b want 1", n, last); end
    end
    cyc(0, 0, 4'h0, 0, 0);
    checks++; if (icount !== 8'd9) begin errors++; $display("FAIL jump_icount got %0d want 9", icount); end
  endtask

  task automatic test_halt();
    cyc(1, 0, 4'hF, 0, 0);
    cyc(1, 0, 4'hF, 0, 0);
    cyc(1, 0, 4'hF, 0, 0);
    checks++; if (ctrl !== 16'h0000 || last !== 1'b1) begin errors++; $display("FAIL hlt_t2 got ctrl=%h last=%b want 0000/1", ctrl, last); end
    for (int i = 0; i < 10; i++) begin
      cyc(1, i[0], 4'h5, 1, 1);
      checks++;
      if (halted !== 1'b1 || ctrl !== 16'h0000 || stage !== 3'd0 || icount !== 8'd10) begin
        errors++;
        $display("FAIL halt_hold cyc%0d got h=%b c=%h s=%0d i=%0d want 1/0000/0/10", i, halted, ctrl, stage, icount);
      end
    end
    do_reset();
    cyc(1, 0, 4'h5, 0, 0);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halted); end
    checks++; if (icount !== 8'd0) begin errors++; $display("FAIL halt_icount_clr got %0d want 0", icount); end
    checks++; if (ctrl !== 16'h1200) begin errors++; $display("FAIL halt_restart_ctrl got %h want 1200", ctrl); end
  endtask

  task automatic test_single_step();
    logic [15:0] lda [4] = '{16'h1200, 16'h0C10, 16'h0260, 16'h0401};
    int s = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(0, (k % 3) == 2, 4'h1, 0, 0);
      checks++; if (stage !== 3'(s)) begin errors++; $display("FAIL step_stage cyc%0d got %0d want %0d", k, stage, s); end
      checks++;
      if (ctrl !== (((k % 3) == 2) ? lda[s] : 16'h0000)) begin
        errors++;
        $display("FAIL step_ctrl cyc%0d got %h want %h", k, ctrl, ((k % 3) == 2) ? lda[s] : 16'h0000);
      end
      if ((k % 3) == 2) s = (s + 1) % 4;
    end
    cyc(0, 0, 4'h1, 0, 0);
    checks++; if (stage !== 3'd0 || icount !== 8'd1) begin errors++; $display("FAIL step_retire got s=%0d i=%0d want 0/1", stage, icount); end
  endtask

  task automatic test_rst_mid_and_illegal();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 4'h2, 0, 0);
    checks++; if (stage !== 3'd3 || ctrl !== 16'h0404) begin errors++; $display("FAIL mid_t3 got s=%0d c=%h want 3/0404", stage, ctrl); end
    rst = 1'b1;
    cyc(1, 0, 4'hA, 0, 0);
    rst = 1'b0;
    checks++; if (stage !== 3'd0 || ctrl !== 16'h1200) begin errors++; $display("FAIL mid_rst got s=%0d c=%h want 0/1200", stage, ctrl); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_t0 got %b want 0", illegal); end
    cyc(1, 0, 4'hA, 0, 0);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_t1 got %b want 0", illegal); end
    cyc(1, 0, 4'hA, 0, 0);
    checks++; if (illegal !== 1'b1 || last !== 1'b1 || ctrl !== 16'h0000) begin errors++; $display("FAIL illegal_t2 got il=%b l=%b c=%h want 1/1/0000", illegal, last, ctrl); end
    cyc(1, 0, 4'hA, 0, 0);
    checks++; if (stage !== 3'd0 || illegal !== 1'b0 || icount !== 8'd1) begin errors++; $display("FAIL illegal_after got s=%0d il=%b i=%0d want 0/0/1", stage, illegal, icount); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_sub();
    test_jumps_t2();
    test_halt();
    test_single_step();
    test_rst_mid_and_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cpu_ctrl_seq
`default_nettype wire
